// File: rtl/vgatest.sv
// Fixed-timing VGA test-pattern generator: free-running h/v counters, registered
// active-low syncs and an RRRGGGBB pixel carrying colour bars or an XOR pattern.
// Optional macro VGATEST_BORDER_EN forces a white 1-pixel frame around the visible area.
module vgatest #(
    parameter int H_VISIBLE    = 720,
    parameter int H_SYNC_START = 756,
    parameter int H_SYNC_LEN   = 72,
    parameter int H_TOTAL      = 936,
    parameter int V_VISIBLE    = 400,
    parameter int V_SYNC_START = 402,
    parameter int V_SYNC_LEN   = 2,
    parameter int V_TOTAL      = 410
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pattern_sel,
    output logic [7:0] pixel,
    output logic       hsync,
    output logic       vsync
);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] H_SS       = 10'(H_SYNC_START);
    localparam logic [9:0] H_SE       = 10'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_VIS      = 9'(V_VISIBLE);
    localparam logic [8:0] V_SS       = 9'(V_SYNC_START);
    localparam logic [8:0] V_SE       = 9'(V_SYNC_START + V_SYNC_LEN);
    localparam int         BAR_W      = H_VISIBLE / 8;
`ifdef VGATEST_BORDER_EN
    localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
    localparam logic [8:0] V_VIS_LAST = 9'(V_VISIBLE - 1);
`endif

    logic [9:0] h_q, h_d;
    logic [8:0] v_q, v_d;
    logic [7:0] pixel_q, pixel_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       visible_s;
    logic [2:0] bar_k_s;
    logic [7:0] pattern_s;

    // Next counter position and the decode of the current position.
    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = 10'd0;
            if (v_q == V_LAST) begin
                v_d = 9'd0;
            end else begin
                v_d = v_q + 9'd1;
            end
        end else begin
            v_d = v_q;
        end

        bar_k_s = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if ({22'd0, h_q} >= 32'(i * BAR_W)) begin
                bar_k_s = 3'(i);
            end else begin
                bar_k_s = bar_k_s;
            end
        end

        if (pattern_sel) begin
            pattern_s = {{3{bar_k_s[2]}}, {3{bar_k_s[1]}}, {2{bar_k_s[0]}}};
        end else begin
            pattern_s = h_q[7:0] ^ v_q[7:0];
        end

        visible_s = (h_q < H_VIS) && (v_q < V_VIS);
`ifdef VGATEST_BORDER_EN
        if (visible_s && ((h_q == 10'd0) || (h_q == H_VIS_LAST) ||
                          (v_q == 9'd0) || (v_q == V_VIS_LAST))) begin
            pixel_d = 8'hFF;
        end else if (visible_s) begin
            pixel_d = pattern_s;
        end else begin
            pixel_d = 8'h00;
        end
`else
        if (visible_s) begin
            pixel_d = pattern_s;
        end else begin
            pixel_d = 8'h00;
        end
`endif

        hsync_d = !((h_q >= H_SS) && (h_q < H_SE));
        vsync_d = !((v_q >= V_SS) && (v_q < V_SE));
    end

    // Counters and outputs advance together, so pins lag the counters by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q     <= 10'd0;
            v_q     <= 9'd0;
            pixel_q <= 8'h00;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            pixel_q <= pixel_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign pixel = pixel_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;

endmodule

// File: tb/tb_vgatest.sv
// Directed bench for vgatest: horizontal timing at default values, vertical
// timing shortened (12 visible / sync 14..15 / 20 lines) so several frames fit.
module tb_vgatest;

    localparam int HT    = 936;
    localparam int VT    = 20;
    localparam int FRAME = HT * VT;
`ifdef VGATEST_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pattern_sel = 1'b1;
    logic [7:0] pixel;
    logic       hsync;
    logic       vsync;

    int tests  = 0;
    int errors = 0;
    int cur    = 0;

    typedef struct {
        int         f;
        bit         sel;
        int         h;
        int         v;
        logic [7:0] pix;
        bit         hs;
        bit         vs;
    } vec_t;

    vec_t vecs[$];

    vgatest #(
        .V_VISIBLE(12), .V_SYNC_START(14), .V_SYNC_LEN(2), .V_TOTAL(20)
    ) dut (
        .clk(clk), .rst(rst), .pattern_sel(pattern_sel),
        .pixel(pixel), .hsync(hsync), .vsync(vsync)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bexp(int h, int v, logic [7:0] val);
        if (BORDER && h < 720 && v < 12 && (h == 0 || h == 719 || v == 0 || v == 11))
            return 8'hFF;
        return val;
    endfunction

    function automatic vec_t mk(int f, bit sel, int h, int v, logic [7:0] pix, bit hs, bit vs);
        vec_t r;
        r.f = f; r.sel = sel; r.h = h; r.v = v;
        r.pix = bexp(h, v, pix); r.hs = hs; r.vs = vs;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cur++;
    endtask

    task automatic check(string name, logic [7:0] pg, logic [7:0] pe, bit hg, bit he, bit vg, bit ve);
        tests++;
        if (pg !== pe || hg !== he || vg !== ve) begin
            errors++;
            $display("FAIL %s: got pixel=%02h hsync=%0b vsync=%0b, want pixel=%02h hsync=%0b vsync=%0b",
                     name, pg, hg, vg, pe, he, ve);
        end
    endtask

    initial begin
        // Frame 0, colour bars
        vecs.push_back(mk(0, 1,   0,  0, 8'h00, 1, 1));
        vecs.push_back(mk(0, 1,  89,  0, 8'h00, 1, 1));
        vecs.push_back(mk(0, 1,  90,  0, 8'h03, 1, 1));
        vecs.push_back(mk(0, 1, 630,  0, 8'hFF, 1, 1));
        vecs.push_back(mk(0, 1,  90,  1, 8'h03, 1, 1));
        vecs.push_back(mk(0, 1, 179,  1, 8'h03, 1, 1));
        vecs.push_back(mk(0, 1, 180,  1, 8'h1C, 1, 1));
        vecs.push_back(mk(0, 1, 630,  1, 8'hFF, 1, 1));
        vecs.push_back(mk(0, 1, 719,  1, 8'hFF, 1, 1));
        vecs.push_back(mk(0, 1, 720,  1, 8'h00, 1, 1));
        vecs.push_back(mk(0, 1, 755,  1, 8'h00, 1, 1));
        vecs.push_back(mk(0, 1, 756,  1, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 827,  1, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 828,  1, 8'h00, 1, 1));
        vecs.push_back(mk(0, 1, 935,  1, 8'h00, 1, 1));
        vecs.push_back(mk(0, 1, 935, 13, 8'h00, 1, 1));
        vecs.push_back(mk(0, 1,   0, 14, 8'h00, 1, 0));
        vecs.push_back(mk(0, 1, 800, 15, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1,   0, 16, 8'h00, 1, 1));
        vecs.push_back(mk(0, 1, 935, 19, 8'h00, 1, 1));
        // Frame 1: restart, then XOR with mid-frame pattern switching
        vecs.push_back(mk(1, 1,   0,  0, 8'h00, 1, 1));
        vecs.push_back(mk(1, 0, 100,  0, 8'h64, 1, 1));
        vecs.push_back(mk(1, 1, 100,  1, 8'h03, 1, 1));
        vecs.push_back(mk(1, 0, 101,  1, 8'h64, 1, 1));
        vecs.push_back(mk(1, 0,   5,  3, 8'h06, 1, 1));
        vecs.push_back(mk(1, 0,   0,  5, 8'h05, 1, 1));
        vecs.push_back(mk(1, 0,   1,  5, 8'h04, 1, 1));
        vecs.push_back(mk(1, 0, 719,  5, 8'hCA, 1, 1));
        vecs.push_back(mk(1, 0, 300, 10, 8'h26, 1, 1));
        vecs.push_back(mk(1, 0, 800, 10, 8'h00, 0, 1));
        vecs.push_back(mk(1, 0, 300, 11, 8'h27, 1, 1));
        vecs.push_back(mk(1, 0,   5, 12, 8'h00, 1, 1));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", pixel, 8'h00, hsync, 1'b1, vsync, 1'b1);

        rst = 1'b0;
        tick();
        cur = 0;

        foreach (vecs[i]) begin
            int target;
            target = vecs[i].f * FRAME + vecs[i].v * HT + vecs[i].h;
            pattern_sel = vecs[i].sel;
            while (cur < target) tick();
            check($sformatf("vec%0d_f%0d_h%0d_v%0d", i, vecs[i].f, vecs[i].h, vecs[i].v),
                  pixel, vecs[i].pix, hsync, vecs[i].hs, vsync, vecs[i].vs);
        end

        // Mid-frame reset pulse near (400,5) of frame 1 while showing sync lines' neighbour
        pattern_sel = 1'b1;
        while (cur < FRAME + 5 * HT + 400) tick();
        rst = 1'b1;
        tick();
        check("rst_pulse_out", pixel, 8'h00, hsync, 1'b1, vsync, 1'b1);
        rst = 1'b0;
        tick();
        cur = 0;
        check("after_rst_00", pixel, bexp(0, 0, 8'h00), hsync, 1'b1, vsync, 1'b1);
        while (cur < 755) tick();
        check("after_rst_h755", pixel, 8'h00, hsync, 1'b1, vsync, 1'b1);
        tick();
        check("after_rst_h756", pixel, 8'h00, hsync, 1'b0, vsync, 1'b1);
        pattern_sel = 1'b0;
        while (cur < 3 * HT + 5) tick();
        check("after_rst_xor", pixel, 8'h06, hsync, 1'b1, vsync, 1'b1);
        while (cur < 14 * HT) tick();
        check("after_rst_vsync", pixel, 8'h00, hsync, 1'b1, vsync, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
